// File: rtl/display_pkg.sv
// Shared types and defaults for the rotating display front end.
// Holds the rotation tracker FSM encoding and default widths.
package display_pkg;

  localparam int THETA_RES_DEF = 27;
  localparam int SCAN_RATE_DEF = 32;

  typedef logic [THETA_RES_DEF-1:0] theta_t;
  typedef logic [$clog2(SCAN_RATE_DEF)-1:0] col_t;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    LOCKED
  } tracker_state_t;

endpackage

// File: rtl/rotation_tracker_debouncer.sv
// IR index sensor conditioning: 2-FF synchronizer plus stability filter.
// Emits the debounced level and a single-cycle pulse on its falling edge.
module ir_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic ir_in,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          done;

  assign done = (s2 != level) && (cnt == LAST);
  assign fall = done && level;

  // Bring the asynchronous sensor into the clock domain; idle = beam clear.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= ir_in;
      s2 <= s1;
    end
  end

  // Count consecutive samples that disagree with the level; flip when full.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      level <= 1'b1;
      cnt   <= '0;
    end else if (s2 == level) begin
      cnt <= '0;
    end else if (done) begin
      level <= s2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rotation_tracker.sv
// Rotation timing for the spinning arm: theta, period and column indices.
// Column stepping uses a Bresenham accumulator so no divider is needed.
module rotation_tracker
  import display_pkg::*;
#(
  parameter int THETA_RES       = THETA_RES_DEF,
  parameter int SCAN_RATE       = SCAN_RATE_DEF,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int MIN_PERIOD      = 1024
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         ir_in,
  output logic [THETA_RES-1:0]         theta,
  output logic [THETA_RES-1:0]         period,
  output logic                         period_ready,
  output logic [$clog2(SCAN_RATE)-1:0] column_index1,
  output logic [$clog2(SCAN_RATE)-1:0] column_index2,
  output logic                         locked
);

  localparam int CW = $clog2(SCAN_RATE);
  localparam int AW = THETA_RES + CW;

  localparam logic [THETA_RES:0]   T_MAX = {1'b0, {THETA_RES{1'b1}}};
  localparam logic [THETA_RES-1:0] T_MIN = THETA_RES'(MIN_PERIOD - 1);
  localparam logic [AW-1:0]        STEP  = AW'(SCAN_RATE);
  localparam logic [CW-1:0]        C_MAX = CW'(SCAN_RATE - 1);
  localparam logic [CW-1:0]        HALF  = CW'(SCAN_RATE / 2);

  tracker_state_t state;
  tracker_state_t state_n;

  logic               deb_level;
  logic               deb_fall;
  logic               trip;
  logic               accept;
  logic               load;
  logic               ovf;
  logic [THETA_RES:0] theta_p1;
  logic [AW-1:0]      acc;
  logic [AW-1:0]      acc_sum;
  logic [AW-1:0]      period_w;
  logic               step;

  ir_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .ir_in   (ir_in),
    .level   (deb_level),
    .fall    (deb_fall)
  );

  // A trip is only meaningful when leaving the clear level.
  assign trip     = deb_fall && deb_level;
  assign theta_p1 = {1'b0, theta} + 1'b1;
  assign ovf      = theta_p1[THETA_RES];
  assign accept   = trip && ((state == IDLE) || (theta >= T_MIN));
  assign locked   = (state == LOCKED);
  assign acc_sum  = acc + STEP;
  assign period_w = {{CW{1'b0}}, period};
  assign step     = (acc_sum >= period_w);

  assign column_index2 = column_index1 + HALF;

  // Next-state: trips advance toward LOCKED, saturation drops to IDLE.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_n = SYNC;
      end
      SYNC, LOCKED: begin
        if (accept) begin
          if (ovf) begin
            state_n = IDLE;
          end else begin
            state_n = LOCKED;
            load    = 1'b1;
          end
        end else if (theta_p1 >= T_MAX) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_n;
  end

  // Theta counts cycles since the last accepted trip and saturates.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in)  theta <= '0;
    else if (accept) theta <= '0;
    else if (!ovf)   theta <= theta_p1[THETA_RES-1:0];
  end

  // Latch the finished revolution length with a one-cycle strobe.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      period       <= '0;
      period_ready <= 1'b0;
    end else begin
      period_ready <= load;
      if (load) period <= theta_p1[THETA_RES-1:0];
    end
  end

  // Bresenham column stepper, restarted on every trip and outside LOCKED.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in || accept || (state_n != LOCKED)) begin
      acc           <= '0;
      column_index1 <= '0;
    end else if (step) begin
      acc <= acc_sum - period_w;
      if (column_index1 != C_MAX) column_index1 <= column_index1 + 1'b1;
    end else begin
      acc <= acc_sum;
    end
  end

endmodule
